// File: rtl/ofmap_collector_if.sv
// Stream bundle between the MAC array, the ofmap collector and the writeback stage.
// The slave modport is the collector's view; the master modport is the array/writeback side.
interface ofmap_collector_if #(
    parameter int MAC_COL        = 16,
    parameter int OFMAP_BITWIDTH = 32
);
    logic [MAC_COL-1:0]                ofmap_valid_in;
    logic [MAC_COL*OFMAP_BITWIDTH-1:0] ofmap_data_in;
    logic                              out_valid;
    logic                              out_ready;
    logic [MAC_COL*OFMAP_BITWIDTH-1:0] out_data;

    modport slave (
        input  ofmap_valid_in,
        input  ofmap_data_in,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output ofmap_valid_in,
        output ofmap_data_in,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/ofmap_collector.sv
// Deskews the systolic array's per-column ofmap streams into aligned vectors, buffers them
// in a FWFT FIFO and reports frame/skew/overflow status. OFMAP_COLLECTOR_RELU_EN adds per-lane ReLU.
module ofmap_collector #(
    parameter int MAC_COL        = 16,
    parameter int OFMAP_BITWIDTH = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int FRAME_LEN      = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    ofmap_collector_if.slave              bus,
    output logic [$clog2(FIFO_DEPTH):0]   out_count,
    output logic                          frame_done,
    output logic                          skew_err,
    output logic                          overflow_err
);
    localparam int W  = OFMAP_BITWIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef logic [MAC_COL-1:0][W-1:0] vec_t;

    logic [MAC_COL-1:0] dly_valid;
    vec_t               dly_data;
    vec_t               lane_next;

    genvar gi;
    generate
        for (gi = 0; gi < MAC_COL; gi++) begin : g_col
            localparam int DEPTH = MAC_COL - 1 - gi;
            if (DEPTH == 0) begin : g_pass
                assign dly_valid[gi] = bus.ofmap_valid_in[gi];
                assign dly_data[gi]  = bus.ofmap_data_in[gi*W +: W];
            end else begin : g_shift
                logic [DEPTH-1:0] v_reg;
                logic [DEPTH-1:0][W-1:0] d_reg;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_reg <= '0;
                        d_reg <= '0;
                    end else begin
                        v_reg[0] <= bus.ofmap_valid_in[gi];
                        d_reg[0] <= bus.ofmap_data_in[gi*W +: W];
                        for (int i = 1; i < DEPTH; i++) begin
                            v_reg[i] <= v_reg[i-1];
                            d_reg[i] <= d_reg[i-1];
                        end
                    end
                end
                assign dly_valid[gi] = v_reg[DEPTH-1];
                assign dly_data[gi]  = d_reg[DEPTH-1];
            end

`ifdef OFMAP_COLLECTOR_RELU_EN
            assign lane_next[gi] = dly_data[gi][W-1] ? '0 : dly_data[gi];
`else
            assign lane_next[gi] = dly_data[gi];
`endif
        end
    endgenerate

    // Aligned stage: a vector is only accepted when every delayed column agrees.
    logic aligned_valid_reg;
    vec_t aligned_data_reg;
    logic skew_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            aligned_valid_reg <= 1'b0;
            aligned_data_reg  <= '0;
            skew_err_reg      <= 1'b0;
        end else begin
            aligned_valid_reg <= &dly_valid;
            aligned_data_reg  <= lane_next;
            if ((|dly_valid) && !(&dly_valid))
                skew_err_reg <= 1'b1;
        end
    end

    vec_t            mem [FIFO_DEPTH];
    vec_t            head_reg;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic [FW-1:0]   frame_cnt_reg;
    logic            frame_done_reg;
    logic            overflow_err_reg;
    logic            push, pop, full, push_ok;

    assign push    = aligned_valid_reg;
    assign pop     = (count_reg != '0) && bus.out_ready;
    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign push_ok = push && (!full || pop);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= aligned_data_reg;
    end

    // The head register holds the FIFO front so out_data stays put while idle or stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            head_reg         <= '0;
            frame_cnt_reg    <= '0;
            frame_done_reg   <= 1'b0;
            overflow_err_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (push && full && !pop)
                overflow_err_reg <= 1'b1;

            if (push_ok && ((count_reg == '0) || (pop && count_reg == CW'(1))))
                head_reg <= aligned_data_reg;
            else if (pop && count_reg > CW'(1))
                head_reg <= mem[rd_ptr_reg + PW'(1)];

            frame_done_reg <= 1'b0;
            if (pop) begin
                if (frame_cnt_reg == FW'(FRAME_LEN - 1)) begin
                    frame_cnt_reg  <= '0;
                    frame_done_reg <= 1'b1;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + FW'(1);
                end
            end
        end
    end

    assign bus.out_valid = (count_reg != '0);
    assign bus.out_data  = head_reg;
    assign out_count     = count_reg;
    assign frame_done    = frame_done_reg;
    assign skew_err      = skew_err_reg;
    assign overflow_err  = overflow_err_reg;
endmodule

// File: tb/tb_ofmap_collector.sv
// Schedule-driven bench for ofmap_collector: skewed column stimulus from per-cycle tables,
// a scoreboard queue of expected vectors, and a frame_done model checked every cycle.
module tb_ofmap_collector;
    localparam int M  = 8;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int FL = 4;
    localparam int NC = 96;

    typedef logic [M*W-1:0] vec_t;
    typedef struct {
        logic [W-1:0] in_val;
        logic [W-1:0] want;
    } relu_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ofmap_collector_if #(.MAC_COL(M), .OFMAP_BITWIDTH(W)) bus();
    logic [$clog2(D):0] out_count;
    logic frame_done, skew_err, overflow_err;

    ofmap_collector #(
        .MAC_COL(M), .OFMAP_BITWIDTH(W), .FIFO_DEPTH(D), .FRAME_LEN(FL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .out_count(out_count),
        .frame_done(frame_done),
        .skew_err(skew_err),
        .overflow_err(overflow_err)
    );

    logic [M-1:0] sv   [NC];
    logic [W-1:0] sd   [NC][M];
    logic         sr   [NC];
    logic         srdy [NC];

    int   cnt_log [NC];
    logic vld_log [NC];
    vec_t dat_log [NC];
    logic sk_log  [NC];
    logic ov_log  [NC];

    vec_t exp_q [$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   first_valid, fd_pulses, pop_total;

    task automatic chk(input string name, input vec_t act, input vec_t req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef OFMAP_COLLECTOR_RELU_EN
        return v[W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic clear_sched();
        for (int t = 0; t < NC; t++) begin
            sv[t]   = '0;
            sr[t]   = 1'b0;
            srdy[t] = 1'b1;
            for (int c = 0; c < M; c++) sd[t][c] = '0;
        end
    endtask

    // Schedules one vector: column c valid at cycle s+c (one extra cycle on column 'late').
    task automatic add_vec(input int s, input logic [W-1:0] base, input bit step,
                           input int late, input bit expect_it);
        vec_t e;
        logic [W-1:0] lane;
        int cc;
        for (int c = 0; c < M; c++) begin
            lane = step ? base + W'(c) : base;
            cc = s + c + ((c == late) ? 1 : 0);
            sv[cc][c] = 1'b1;
            sd[cc][c] = lane;
            e[c*W +: W] = relu(lane);
        end
        if (expect_it) exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ofmap_valid_in = '0;
        bus.ofmap_data_in  = '0;
        bus.out_ready      = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        clear_sched();
    endtask

    task automatic run(input int ncyc);
        int   pops;
        bit   exp_fd;
        vec_t e;
        pops = 0;
        exp_fd = 1'b0;
        first_valid = -1;
        fd_pulses = 0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            rst = sr[t];
            bus.ofmap_valid_in = sv[t];
            for (int c = 0; c < M; c++) bus.ofmap_data_in[c*W +: W] = sd[t][c];
            bus.out_ready = srdy[t];

            chk("frame_done", vec_t'(frame_done), vec_t'(exp_fd));
            if (frame_done) fd_pulses++;
            if (bus.out_valid && first_valid < 0) first_valid = t;
            cnt_log[t] = int'(out_count);
            vld_log[t] = bus.out_valid;
            dat_log[t] = bus.out_data;
            sk_log[t]  = skew_err;
            ov_log[t]  = overflow_err;

            exp_fd = 1'b0;
            if (sr[t]) begin
                pops = 0;
            end else if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got beat lane0=%0h at cycle %0d, want none",
                             bus.out_data[W-1:0], t);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.out_data, e);
                    $display("pop %0d cycle %0d lane0=%0h lane%0d=%0h", pop_total, t,
                             bus.out_data[W-1:0], M-1, bus.out_data[(M-1)*W +: W]);
                end
                exp_fd = ((pops % FL) == FL - 1);
                pops++;
                pop_total++;
            end
        end
    endtask

    relu_rec_t rtab [6];

    initial begin
        pop_total = 0;

        // Reset state
        do_reset();
        chk("rst_out_valid", vec_t'(bus.out_valid), '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_count", vec_t'(out_count), '0);
        chk("rst_frame_done", vec_t'(frame_done), '0);
        chk("rst_skew_err", vec_t'(skew_err), '0);
        chk("rst_overflow_err", vec_t'(overflow_err), '0);

        // 1: ideal skew, 20 back-to-back vectors, always ready
        for (int n = 0; n < 20; n++) add_vec(2 + n, W'(1000 * n), 1'b1, -1, 1'b1);
        run(40);
        chk("t1_latency", vec_t'(first_valid), vec_t'(2 + M + 1));
        chk("t1_drained", vec_t'(exp_q.size()), '0);
        chk("t1_skew_err", vec_t'(skew_err), '0);
        chk("t1_overflow_err", vec_t'(overflow_err), '0);

        // 2: backpressure, 12 vectors into an 8-deep FIFO, release at cycle 40
        do_reset();
        for (int n = 0; n < 12; n++) add_vec(2 + n, W'(5000 + 100 * n), 1'b1, -1, n < D);
        for (int t = 0; t < NC; t++) srdy[t] = (t >= 40);
        run(60);
        chk("t2_count_full", vec_t'(cnt_log[35]), vec_t'(D));
        chk("t2_overflow_err", vec_t'(ov_log[35]), 1);
        chk("t2_drained", vec_t'(exp_q.size()), '0);

        // 3: fill to 8, then simultaneous push/pop while arrivals continue
        do_reset();
        for (int n = 0; n < 16; n++) add_vec(2 + n, W'(9000 + 10 * n), 1'b1, -1, 1'b1);
        for (int t = 0; t < NC; t++) srdy[t] = (t >= 2 + D + M);
        run(50);
        chk("t3_count_a", vec_t'(cnt_log[20]), vec_t'(D));
        chk("t3_count_b", vec_t'(cnt_log[24]), vec_t'(D));
        chk("t3_overflow_err", vec_t'(overflow_err), '0);
        chk("t3_drained", vec_t'(exp_q.size()), '0);

        // 4: column 5 one cycle late on vector 3
        do_reset();
        for (int n = 0; n < 6; n++)
            add_vec(2 + 2 * n, W'(2000 * n + 7), 1'b1, (n == 3) ? 5 : -1, n != 3);
        run(40);
        chk("t4_skew_err", vec_t'(skew_err), 1);
        chk("t4_overflow_err", vec_t'(overflow_err), '0);
        chk("t4_drained", vec_t'(exp_q.size()), '0);

        // 5: frame boundaries, then reset during the 9th vector's skew window
        do_reset();
        for (int n = 0; n < 8; n++) add_vec(2 + n, W'(300 + n), 1'b0, -1, 1'b1);
        add_vec(9 + M + 4, W'(777), 1'b1, -1, 1'b0);
        for (int t = 9 + M + 4 + 3; t <= 9 + M + 4 + M - 1; t++) sr[t] = 1'b1;
        run(45);
        chk("t5_fd_pulses", vec_t'(fd_pulses), 2);
        chk("t5_post_rst_valid", vec_t'(vld_log[9 + 2 * M + 4]), '0);
        chk("t5_post_rst_data", dat_log[9 + 2 * M + 4], '0);
        chk("t5_post_rst_count", vec_t'(cnt_log[9 + 2 * M + 4]), '0);
        chk("t5_post_rst_flags", vec_t'({sk_log[9 + 2 * M + 4], ov_log[9 + 2 * M + 4]}), '0);
        chk("t5_drained", vec_t'(exp_q.size()), '0);

        // 6: sign handling table
`ifdef OFMAP_COLLECTOR_RELU_EN
        rtab[0] = '{32'hFFFF_FFF9, 32'h0000_0000};
        rtab[1] = '{32'h0000_0000, 32'h0000_0000};
        rtab[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        rtab[3] = '{32'h8000_0000, 32'h0000_0000};
        rtab[4] = '{32'h0000_04D2, 32'h0000_04D2};
        rtab[5] = '{32'hFFFF_FFFF, 32'h0000_0000};
`else
        rtab[0] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9};
        rtab[1] = '{32'h0000_0000, 32'h0000_0000};
        rtab[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        rtab[3] = '{32'h8000_0000, 32'h8000_0000};
        rtab[4] = '{32'h0000_04D2, 32'h0000_04D2};
        rtab[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
`endif
        do_reset();
        for (int r = 0; r < 6; r++) begin
            vec_t e;
            add_vec(2 + r, rtab[r].in_val, 1'b0, -1, 1'b0);
            for (int c = 0; c < M; c++) e[c*W +: W] = rtab[r].want;
            exp_q.push_back(e);
        end
        run(30);
        chk("t6_drained", vec_t'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ofmap_collector.md
Name: ofmap_collector

Overview:
- Sits directly downstream of the systolic MAC array and consumes its per-column ofmap_valid_out / ofmap_data_out streams.
- The array emits column c one cycle after column c-1 for the same output vector. This block deskews the columns into one aligned MAC_COL-wide vector per output pixel.
- Aligned vectors are buffered in a small FIFO and presented on a valid/ready interface to the writeback stage.
- The block also counts vectors per frame and flags skew and overflow faults.

Parameters:
- MAC_COL, 16, number of array columns (lanes per output vector).
- OFMAP_BITWIDTH, 32, bits per column result, two's complement.
- FIFO_DEPTH, 8, aligned-vector entries buffered; must be a power of 2, at least 2.
- FRAME_LEN, 1024, vectors per frame; frame_done fires on the last one.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- ofmap_valid_in  input  MAC_COL  per-column valid, from the array's ofmap_valid_out.
- ofmap_data_in  input  MAC_COL*OFMAP_BITWIDTH  packed per-column data; column c occupies bits [c*OFMAP_BITWIDTH +: OFMAP_BITWIDTH].
- out_valid  output  1  FIFO head holds an aligned vector.
- out_ready  input  1  consumer accepts the head this cycle.
- out_data  output  MAC_COL*OFMAP_BITWIDTH  aligned vector at the FIFO head, same lane packing as the input.
- out_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_done  output  1  one-cycle pulse when vector FRAME_LEN-1 of a frame is popped.
- skew_err  output  1  sticky: aligned column valids disagreed.
- overflow_err  output  1  sticky: a vector was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clock edge) clears everything: delay lines, the aligned stage, FIFO pointers, the frame counter, and all flags.
  - After reset: out_valid=0, out_data=0, out_count=0, frame_done=0, skew_err=0, overflow_err=0.
  - Inputs presented in the reset cycle are discarded.
  - Reset mid-frame drops all in-flight and buffered vectors; the frame count restarts at 0.
- Deskew stage:
  - Column c valid and data pass through a (MAC_COL-1-c)-stage register delay; column MAC_COL-1 has zero delay.
  - The aligned stage registers all delayed columns in a single edge.
  - aligned_valid = AND of the delayed valids.
  - If the delayed valids are neither all 0 nor all 1, set skew_err and discard the vector. It is not pushed.
- FIFO:
  - First-word-fall-through.
  - push = aligned_valid; pop = out_valid & out_ready.
  - Push is written one edge after the aligned stage.
- Latency:
  - Column MAC_COL-1 valid sampled at edge k produces out_valid=1 after edge k+1.
  - Column 0 of the same vector arrives MAC_COL-1 cycles earlier, so its end-to-end latency is MAC_COL+1 cycles.
- Full FIFO:
  - push without pop: the vector is dropped, overflow_err is set, and contents are unchanged.
  - push with pop in the same cycle: both happen, and count stays at FIFO_DEPTH.
- Empty FIFO:
  - out_valid=0; out_ready is ignored.
  - A push into an empty FIFO is visible on the next cycle. There is no same-cycle bypass.
- out_data holds its value whenever out_valid=0 or the head is not popped.
- Pointers wrap modulo FIFO_DEPTH.
- Frame counter:
  - Increments on each pop.
  - On the pop where the count is FRAME_LEN-1: frame_done=1 for exactly that cycle (registered, asserted after the pop edge), and the counter wraps to 0.
- skew_err and overflow_err clear only on reset.
- Arithmetic: data passes through unmodified except as described under Optional Feature.

Optional Feature:
- Macro: OFMAP_COLLECTOR_RELU_EN.
- Defined: ReLU is applied per lane in the aligned stage. Any lane whose bit OFMAP_BITWIDTH-1 is 1 is written as 0; non-negative lanes pass unchanged. Latency is unchanged.
- Undefined: lanes pass raw two's-complement values. No extra logic is present.

Test Plan:
1. Ideal skew, out_ready=1: feed 20 vectors, column c valid at cycle t+c, lane value = 1000*n+c. Expect 20 out_valid beats in order with lanes matching; the first beat appears MAC_COL+1 cycles after column 0's first valid; skew_err=0, overflow_err=0.
2. Backpressure: out_ready=0 while 12 vectors arrive (FIFO_DEPTH=8). Expect out_count saturates at 8 and overflow_err=1; after releasing out_ready, exactly vectors 0..7 drain in order.
3. Full plus simultaneous push/pop: fill to 8, then hold out_ready=1 during continuous arrival. Expect out_count stays 8, no drop, and overflow_err remains 0.
4. Skew fault: column 5's valid is one cycle late for vector 3. Expect skew_err=1 and vector 3 absent from the output; vectors 2 and 4 are intact.
5. Frame boundary: FRAME_LEN=4, stream 9 vectors. Expect frame_done pulses on the 4th and 8th pops only, each exactly one cycle. Assert rst during the 9th vector's skew window; all outputs are 0 the next cycle and no vector emerges.
6. With OFMAP_COLLECTOR_RELU_EN defined: lane values -7, 0, 32'h7FFFFFFF, 32'h80000000. Expect outputs 0, 0, 32'h7FFFFFFF, 0. Without the macro, values pass unchanged.
